drops_matrix_tx: RTL and testbench
==================================

Name: drops_matrix_tx

Overview:
Serial display transmitter for the drops game. It holds a double-buffered 8x8 frame of drop and player pixels written by the game logic. It scans the frame row by row and shifts each row out to an external 74HC595-style column shift register, with a latch strobe and a one-hot row select for a multiplexed LED matrix. It sits between the game core and the uo_out pins; the bench observes its serial stream as the receiving end.

Parameters:
ROWS, 8, number of matrix rows; fixed at 8 in this revision.
COLS, 8, bits shifted per row; fixed at 8 in this revision.
CLK_DIV, 2, clk cycles per sr_clk half-period; legal values 1..15.
HOLD_CYC, 16, clk cycles a latched row is displayed before the next row shift begins; legal values 1..255.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; scanning runs only while high
wr_en  in  1  write one row of the back buffer this cycle
wr_row  in  3  back-buffer row index for wr_en
wr_data  in  8  row pixels; bit 7 = leftmost column
swap_req  in  1  single-cycle pulse: request back/front buffer swap
sr_data  out  1  serial column data, MSB first
sr_clk  out  1  shift clock to external register; data sampled on rising edge
sr_latch  out  1  storage-register latch strobe
row_sel  out  8  one-hot active row; bit r = row r
frame_done  out  1  one-cycle pulse after row 7 has been latched
swap_pending  out  1  swap requested but not yet applied

Behaviour:
- Reset (async, rst_n=0): sr_data=0, sr_clk=0, sr_latch=0, row_sel=8'h00, frame_done=0, swap_pending=0. Both buffers cleared to 0. Front buffer index=0, row counter=0, state=IDLE.
- States: IDLE, SHIFT, LATCH, HOLD.
- IDLE -> SHIFT on the first cycle with ena=1. Outputs stay at their reset values while in IDLE.
- SHIFT, per bit (COLS bits):
  - sr_data is driven with the current bit while sr_clk=0 for CLK_DIV cycles.
  - sr_clk=1 for CLK_DIV cycles.
  - sr_data is stable throughout the high phase.
  - Bit order is wr_data[7] first.
- LATCH, entered after the falling edge of the last bit:
  - sr_latch=1 for CLK_DIV cycles.
  - row_sel changes to the one-hot value for the current row on the same cycle sr_latch rises.
- HOLD:
  - sr_latch=0 for HOLD_CYC cycles.
  - Then the row counter increments modulo 8 and the state returns to SHIFT.
- Row period = 2*COLS*CLK_DIV + CLK_DIV + HOLD_CYC cycles. With defaults this is 50 cycles; a frame is 400 cycles.
- frame_done pulses on the first HOLD cycle of row 7.
- Row data is captured from the front buffer at SHIFT entry into a shift register. A swap in mid-row never alters the row being shifted.
- Writes:
  - wr_en always writes the back buffer, in any state including IDLE.
  - Same-cycle wr_en and swap_req: the write lands in the pre-swap back buffer, i.e. it becomes visible after the swap.
- Swap:
  - swap_req sets swap_pending=1.
  - The swap is applied on the cycle frame_done pulses, and swap_pending clears on that cycle.
  - Row 0 of the next frame shows the new front buffer.
  - Multiple requests before a frame boundary collapse into one swap.
  - swap_req coincident with frame_done is applied at that boundary.
  - A swap pending while ena=0 is applied immediately upon entering IDLE.
- ena falling:
  - The current row completes through HOLD.
  - The block then enters IDLE: row_sel=0, row counter reset to 0, sr_* low.
  - ena re-asserted restarts at row 0.
- Reset mid-operation clears everything immediately. There are no partial pulses after rst_n falls.

Test Plan:
- Reset then ena=1 with empty buffers: 8 sr_clk rising edges per row with sr_data=0. sr_latch high for 2 cycles every 50 cycles. row_sel sequences 01,02,04,...,80,01.
- Write row 3 = 8'hA5, pulse swap_req: swap_pending=1 until frame_done. In the next frame, the row-3 bits sampled at sr_clk rising edges are 1,0,1,0,0,1,0,1; all other rows are 0.
- Write row 0 = 8'hFF without a swap: the displayed row 0 stays 8'h00 indefinitely. swap_req mid-frame: row 0 becomes 8'hFF only from the next frame.
- swap_req pulsed 3 times within one frame: exactly one swap. A 4th request after the boundary restores the previous front buffer.
- Drop ena in the middle of the SHIFT of row 2: row 2 finishes (latch plus 16 HOLD cycles), then row_sel=0 and outputs stay low. Re-raise ena: scanning resumes at row 0.
- Assert rst_n=0 during LATCH: all outputs 0 within the same cycle. After release and ena=1, the first latched row_sel is 8'h01 and the buffers read back 0.

Source files
------------

// File: rtl/drops_matrix_tx.sv
// drops_matrix_tx: double-buffered 8x8 frame store scanned row by row
// into an external 74HC595-style column register, with a latch strobe and a
// one-hot row select for a multiplexed LED matrix.
// wr_en and swap_req are single-cycle strobes with no back-pressure. They are
// accepted on any clock edge where they are high, in every state.
module drops_matrix_tx #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CLK_DIV  = 2,
  parameter int HOLD_CYC = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ena,
  input  logic            i_wr_en,
  input  logic [2:0]      i_wr_row,
  input  logic [COLS-1:0] i_wr_data,
  input  logic            i_swap_req,
  output logic            o_sr_data,
  output logic            o_sr_clk,
  output logic            o_sr_latch,
  output logic [ROWS-1:0] o_row_sel,
  output logic            o_frame_done,
  output logic            o_swap_pending,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [2:0] BIT_LAST  = 3'(COLS - 1);
  localparam logic [2:0] ROW_LAST  = 3'(ROWS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_div_cnt;
  logic            r_phase;      // current sr_clk level while shifting
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_hold_cnt;
  logic [2:0]      r_row;
  logic [COLS-1:0] r_shreg;
  logic [ROWS-1:0] r_row_sel;
  logic            r_front;
  logic            r_pending;
  logic [COLS-1:0] r_buf [2][ROWS];

  logic            w_div_end;
  logic            w_frame_done;
  logic            w_swap_apply;
  logic            w_front_eff;
  logic            w_load;
  logic [2:0]      w_load_row;

  assign w_div_end    = (r_div_cnt == DIV_LAST);
  assign w_frame_done = (r_state == S_HOLD) && (r_hold_cnt == 8'd0) && (r_row == ROW_LAST);
  // Swap at the frame boundary (a same-cycle request counts), or at once while idle.
  assign w_swap_apply = (w_frame_done && (r_pending || i_swap_req)) ||
                        ((r_state == S_IDLE) && r_pending);
  // Front buffer as it will be after this edge, so a row loaded on the swap cycle sees the new frame.
  assign w_front_eff  = r_front ^ w_swap_apply;
  assign w_load       = (w_state_nxt == S_SHIFT) && (r_state != S_SHIFT);
  assign w_load_row   = (r_state == S_IDLE) ? 3'd0 : r_row + 3'd1;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: shift 8 bits, latch, hold, then next row or idle when disabled.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_ena) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_div_end && r_phase && (r_bit_cnt == BIT_LAST)) w_state_nxt = S_LATCH;
      S_LATCH: if (w_div_end) w_state_nxt = S_HOLD;
      S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_nxt = i_ena ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scan datapath: clock divider, bit/hold counters, row counter, shift register, row select.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt  <= '0;
      r_phase    <= 1'b0;
      r_bit_cnt  <= '0;
      r_hold_cnt <= '0;
      r_row      <= '0;
      r_shreg    <= '0;
      r_row_sel  <= '0;
    end else begin
      if ((r_state == S_SHIFT) || (r_state == S_LATCH))
        r_div_cnt <= w_div_end ? 4'd0 : r_div_cnt + 4'd1;
      else
        r_div_cnt <= 4'd0;

      if (w_load) begin
        r_phase   <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_shreg   <= r_buf[w_front_eff][w_load_row];
      end else if ((r_state == S_SHIFT) && w_div_end) begin
        r_phase <= ~r_phase;
        if (r_phase) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_shreg   <= r_shreg << 1;
        end
      end

      r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 8'd1 : 8'd0;

      if (w_state_nxt == S_IDLE)
        r_row <= 3'd0;
      else if ((r_state == S_HOLD) && (r_hold_cnt == HOLD_LAST))
        r_row <= r_row + 3'd1;

      if (w_state_nxt == S_IDLE)
        r_row_sel <= '0;
      else if ((r_state == S_SHIFT) && (w_state_nxt == S_LATCH))
        r_row_sel <= ROWS'(1) << r_row;
    end
  end

  // Frame buffers and swap bookkeeping; writes always target the pre-swap back buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          r_buf[b][r] <= '0;
    end else begin
      if (i_wr_en) r_buf[~r_front][i_wr_row] <= i_wr_data;
      if (w_swap_apply) begin
        r_front   <= ~r_front;
        r_pending <= 1'b0;
      end else if (i_swap_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_sr_data      = (r_state == S_SHIFT) && r_shreg[COLS-1];
  assign o_sr_clk       = (r_state == S_SHIFT) && r_phase;
  assign o_sr_latch     = (r_state == S_LATCH);
  assign o_row_sel      = r_row_sel;
  assign o_frame_done   = w_frame_done;
  assign o_swap_pending = r_pending && !w_frame_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_drops_matrix_tx.sv
// tb_drops_matrix_tx: random writes and swaps against a frame-level model.
// The model tracks two 8-byte buffers, a front index and a pending flag, and
// predicts timing from the row period (50) and frame period (400). At each
// frame start it queues the 8 rows that will be displayed; a monitor
// deserialises the 595 stream and pops one entry per latch strobe.
module tb_drops_matrix_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       sr_data;
  logic       sr_clk;
  logic       sr_latch;
  logic [7:0] row_sel;
  logic       frame_done;
  logic       swap_pending;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  drops_matrix_tx dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ena          (ena),
    .i_wr_en        (wr_en),
    .i_wr_row       (wr_row),
    .i_wr_data      (wr_data),
    .i_swap_req     (swap_req),
    .o_sr_data      (sr_data),
    .o_sr_clk       (sr_clk),
    .o_sr_latch     (sr_latch),
    .o_row_sel      (row_sel),
    .o_frame_done   (frame_done),
    .o_swap_pending (swap_pending),
    .o_dbg_state    (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Expected displayed rows: {row index, pixels}.
  logic [10:0] exp_q[$];

  // Behavioural model.
  logic [7:0] m_buf [2][8];
  int         m_front;
  bit         m_pending;
  bit         m_active;
  int         m_t;        // cycles since scanning (re)started at row 0
  logic       drv_ena;
  int         p_wr;
  int         p_swap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] oh(input int r);
    logic [7:0] one;
    one = 8'd1;
    return one << r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        m_buf[b][r] = 8'h00;
    m_front   = 0;
    m_pending = 0;
    m_active  = 0;
    m_t       = 0;
    exp_q.delete();
  endtask

  task automatic push_frame();
    for (int r = 0; r < 8; r++)
      exp_q.push_back({3'(r), m_buf[m_front][r]});
  endtask

  // One clock cycle: check outputs of this cycle, drive inputs, advance model.
  task automatic step(input logic wr, input logic [2:0] row, input logic [7:0] data, input logic sw);
    int         ph;
    logic       exp_fd;
    logic [7:0] exp_rs;
    @(negedge clk);
    exp_fd = m_active && ((m_t % 400) == 384);
    chk("frame_done", frame_done, exp_fd);
    chk("swap_pending", swap_pending, m_pending && !exp_fd);
    if (m_active) begin
      ph = m_t % 50;
      chk("sr_latch", sr_latch, (ph == 32) || (ph == 33));
      chk("sr_clk", sr_clk, (ph < 32) && ((ph % 4) >= 2));
      if (ph >= 32)      exp_rs = oh((m_t / 50) % 8);
      else if (m_t < 32) exp_rs = 8'h00;
      else               exp_rs = oh((m_t / 50 - 1) % 8);
      chk("row_sel", row_sel, exp_rs);
    end else begin
      chk("idle_row_sel", row_sel, 8'h00);
      chk("idle_sr_lines", {sr_data, sr_clk, sr_latch}, 3'b000);
    end
    ena      = drv_ena;
    wr_en    = wr;
    wr_row   = row;
    wr_data  = data;
    swap_req = sw;
    if (wr) m_buf[1 - m_front][row] = data;
    if (m_active) begin
      if (sw) m_pending = 1;
      if (exp_fd) begin
        if (m_pending) begin
          m_front   = 1 - m_front;
          m_pending = 0;
        end
        push_frame();
      end
      if (((m_t % 50) == 49) && !drv_ena) begin
        m_active = 0;
        exp_q.delete();
      end else begin
        m_t++;
      end
    end else begin
      if (m_pending) begin
        m_front   = 1 - m_front;
        m_pending = 0;
      end
      if (sw) m_pending = 1;
      if (drv_ena) begin
        m_active = 1;
        m_t      = 0;
        push_frame();
      end
    end
  endtask

  task automatic rand_step();
    logic wr;
    logic sw;
    wr = ($urandom_range(0, 99) < p_wr);
    sw = m_active && ($urandom_range(0, 999) < p_swap);
    step(wr, 3'($urandom_range(0, 7)), 8'($urandom), sw);
  endtask

  task automatic run(input int n);
    repeat (n) rand_step();
  endtask

  // Advance until the next step lands on frame cycle tt.
  task automatic run_to(input int tt);
    bit hit;
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m_active && ((m_t % 400) == tt)) begin
        hit = 1;
        break;
      end
      rand_step();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL run_to: frame cycle %0d not reached, got active=%0d t=%0d", tt, m_active, m_t);
    end
  endtask

  // Monitor: rebuild each row from sr_clk rising edges and score it at the latch.
  logic       mon_prev_clk;
  logic       mon_prev_latch;
  logic [7:0] mon_cap;
  int         mon_bits;
  int         mon_lat_len;
  logic [10:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_clk   = 1'b0;
      mon_prev_latch = 1'b0;
      mon_cap        = 8'h00;
      mon_bits       = 0;
      mon_lat_len    = 0;
    end else begin
      if (sr_clk && !mon_prev_clk) begin
        mon_cap = {mon_cap[6:0], sr_data};
        mon_bits++;
      end
      if (sr_latch && !mon_prev_latch) begin
        chk("bits_per_row", mon_bits, 8);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_row: got row_sel=%0h data=%0h expected no row", row_sel, mon_cap);
        end else begin
          mon_e = exp_q.pop_front();
          chk("latched_row_sel", row_sel, oh(int'(mon_e[10:8])));
          chk("row_data", mon_cap, mon_e[7:0]);
        end
        mon_bits    = 0;
        mon_lat_len = 0;
      end
      if (sr_latch) mon_lat_len++;
      if (!sr_latch && mon_prev_latch) chk("latch_len", mon_lat_len, 2);
      mon_prev_clk   = sr_clk;
      mon_prev_latch = sr_latch;
    end
  end

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b0;
    wr_en    = 1'b0;
    wr_row   = 3'd0;
    wr_data  = 8'h00;
    swap_req = 1'b0;
    drv_ena  = 1'b0;
    p_wr     = 0;
    p_swap   = 0;
    model_reset();

    #12;
    chk("rst_sr_data", sr_data, 1'b0);
    chk("rst_sr_clk", sr_clk, 1'b0);
    chk("rst_sr_latch", sr_latch, 1'b0);
    chk("rst_row_sel", row_sel, 8'h00);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_swap_pending", swap_pending, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty buffers: zero rows, row_sel walks 01..80 and wraps.
    run(5);
    drv_ena = 1'b1;
    run(810);

    // Row 3 = A5 plus a swap: visible from the next frame on.
    run_to(100);
    step(1'b1, 3'd3, 8'hA5, 1'b0);
    run(20);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    run_to(390);
    run(400);

    // Row 0 = FF without swap stays hidden; a mid-frame swap shows it next frame.
    run_to(50);
    step(1'b1, 3'd0, 8'hFF, 1'b0);
    run_to(200);
    run(400);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    run_to(390);
    run(20);

    // Three requests in one frame collapse to one swap; a fourth swaps back.
    run_to(10);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    run_to(100);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    run_to(300);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    run_to(390);
    run_to(20);
    step(1'b0, 3'd0, 8'h00, 1'b1);

    // Write plus swap on the frame_done cycle: write goes to the old back buffer, then shows.
    run_to(384);
    step(1'b1, 3'd5, 8'h3C, 1'b1);
    run(420);

    // Random traffic.
    p_wr   = 8;
    p_swap = 2;
    run(1600);
    p_wr   = 0;
    p_swap = 0;

    // Drop ena during row 2 shift, with a swap left pending into idle.
    run_to(110);
    drv_ena = 1'b0;
    run(17);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    run(150);
    drv_ena = 1'b1;
    run(450);

    // Reset asserted during the latch of row 1.
    run_to(82);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sr_data", sr_data, 1'b0);
    chk("mid_rst_sr_clk", sr_clk, 1'b0);
    chk("mid_rst_sr_latch", sr_latch, 1'b0);
    chk("mid_rst_row_sel", row_sel, 8'h00);
    chk("mid_rst_frame_done", frame_done, 1'b0);
    chk("mid_rst_swap_pending", swap_pending, 1'b0);
    drv_ena = 1'b0;
    ena     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(3);
    drv_ena = 1'b1;
    run(450);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
